// File: rtl/dm_serial_loader.sv
// Serial bulk loader: MSB-first header (base address, word count) then payload words, written to data memory at incrementing addresses.
// Latency: mem_wr rises the cycle after the last bit of a word; best case DATA_WIDTH+1 cycles per word.
// Backpressure: ser_ready drops in IDLE/WRITE/FIN; optional trailing parity bit when DM_LOADER_PARITY_EN is defined.
module dm_serial_loader #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     ser_valid,
    input  logic                     ser_bit,
    output logic                     ser_ready,
    output logic                     mem_wr,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0]    mem_data,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    localparam int MAX_W = (ADDRESS_WIDTH > DATA_WIDTH) ? ADDRESS_WIDTH : DATA_WIDTH;
    localparam int CNT_W = $clog2(MAX_W + 1);

`ifdef DM_LOADER_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_LEN, S_DATA, S_WRITE, S_PAR, S_FIN
    } state_t;
    localparam state_t S_POST = S_PAR;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_LEN, S_DATA, S_WRITE, S_FIN
    } state_t;
    localparam state_t S_POST = S_FIN;
`endif

    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           bit_cnt_q;
    logic [ADDRESS_WIDTH-1:0]   addr_q;
    logic [ADDRESS_WIDTH-1:0]   words_q;
    logic [DATA_WIDTH-1:0]      word_q;
    logic [ADDRESS_WIDTH-1:0]   mem_address_q;
    logic [DATA_WIDTH-1:0]      mem_data_q;

    logic                       xfer;
    logic                       last_hdr_bit;
    logic                       last_data_bit;
    logic [ADDRESS_WIDTH-1:0]   addr_next;
    logic [ADDRESS_WIDTH-1:0]   len_next;
    logic [DATA_WIDTH-1:0]      word_next;

    assign xfer          = ser_valid & ser_ready;
    assign last_hdr_bit  = (bit_cnt_q == CNT_W'(ADDRESS_WIDTH - 1));
    assign last_data_bit = (bit_cnt_q == CNT_W'(DATA_WIDTH - 1));
    // Left shift with the new bit entering at the LSB keeps every field MSB first.
    assign addr_next     = ADDRESS_WIDTH'({addr_q, ser_bit});
    assign len_next      = ADDRESS_WIDTH'({words_q, ser_bit});
    assign word_next     = DATA_WIDTH'({word_q, ser_bit});

    assign mem_address = mem_address_q;
    assign mem_data    = mem_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ser_ready = 1'b0;
        mem_wr    = 1'b0;
        done      = 1'b0;
        busy      = (state_q != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_ADDR;
            end
            S_ADDR: begin
                ser_ready = 1'b1;
                if (xfer && last_hdr_bit) state_d = S_LEN;
            end
            S_LEN: begin
                ser_ready = 1'b1;
                if (xfer && last_hdr_bit) begin
                    state_d = (len_next == '0) ? S_POST : S_DATA;
                end
            end
            S_DATA: begin
                ser_ready = 1'b1;
                if (xfer && last_data_bit) state_d = S_WRITE;
            end
            S_WRITE: begin
                mem_wr  = 1'b1;
                state_d = (words_q == ADDRESS_WIDTH'(1)) ? S_POST : S_DATA;
            end
`ifdef DM_LOADER_PARITY_EN
            S_PAR: begin
                ser_ready = 1'b1;
                if (xfer) state_d = S_FIN;
            end
`endif
            S_FIN: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef DM_LOADER_PARITY_EN
    logic parity_q;
    logic err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_q     <= '0;
            addr_q        <= '0;
            words_q       <= '0;
            word_q        <= '0;
            mem_address_q <= '0;
            mem_data_q    <= '0;
`ifdef DM_LOADER_PARITY_EN
            parity_q      <= 1'b0;
            err_q         <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        bit_cnt_q <= '0;
`ifdef DM_LOADER_PARITY_EN
                        parity_q  <= 1'b0;
                        err_q     <= 1'b0;
`endif
                    end
                end
                S_ADDR: begin
                    if (xfer) begin
                        addr_q    <= addr_next;
                        bit_cnt_q <= last_hdr_bit ? '0 : bit_cnt_q + CNT_W'(1);
                    end
                end
                S_LEN: begin
                    if (xfer) begin
                        words_q   <= len_next;
                        bit_cnt_q <= last_hdr_bit ? '0 : bit_cnt_q + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        word_q    <= word_next;
                        bit_cnt_q <= last_data_bit ? '0 : bit_cnt_q + CNT_W'(1);
`ifdef DM_LOADER_PARITY_EN
                        parity_q  <= parity_q ^ ser_bit;
`endif
                        // Write port registers load here so mem_wr and the payload appear together in WRITE.
                        if (last_data_bit) begin
                            mem_address_q <= addr_q;
                            mem_data_q    <= word_next;
                        end
                    end
                end
                S_WRITE: begin
                    addr_q  <= addr_q + ADDRESS_WIDTH'(1);
                    words_q <= words_q - ADDRESS_WIDTH'(1);
                end
`ifdef DM_LOADER_PARITY_EN
                S_PAR: begin
                    if (xfer) err_q <= (ser_bit != parity_q);
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: doc/dm_serial_loader.md
Name: dm_serial_loader

Overview:
Serial-to-parallel bulk loader for the data memory write port. Receives a bit stream (header, then payload words), assembles words, and issues single-cycle writes on a wr/address/data_in style port at incrementing addresses. Sits between the bench/debug serial link and the data memory, replacing file-based preload for run-time image loading.

Parameters:
ADDRESS_WIDTH, 8, memory address width; also the width of the header length field.
DATA_WIDTH, 1, memory word width; number of bits assembled per write.

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins a load session when idle
ser_valid  in  1  ser_bit is valid this cycle
ser_bit  in  1  serial data bit, MSB first within every field
ser_ready  out  1  loader accepts a bit this cycle; transfer = ser_valid & ser_ready
mem_wr  out  1  write strobe to data memory, one cycle per word
mem_address  out  ADDRESS_WIDTH  write address
mem_data  out  DATA_WIDTH  write data
busy  out  1  session in progress (any state but IDLE)
done  out  1  one-cycle pulse at end of session
err  out  1  sticky error flag (see Optional Feature)

Behaviour:
- Reset (synchronous, active-high): state=IDLE; ser_ready, mem_wr, busy, done, err = 0; mem_address, mem_data = 0; bit counter and word counter = 0. Reset mid-session aborts immediately, with no further writes.
- States: IDLE, ADDR, LEN, DATA, WRITE, PAR (only with the optional feature), FIN.
- IDLE: ser_ready=0. On start=1, go to ADDR, clear err, and clear the bit counter. start while busy is ignored.
- ADDR: ser_ready=1. Shift in ADDRESS_WIDTH bits into the base address register. After the last bit, go to LEN.
- LEN: shift in ADDRESS_WIDTH bits as word count N.
  - N=0: go to PAR (feature on) or FIN; no writes issued.
  - N>0: go to DATA.
- DATA: shift in DATA_WIDTH bits. After the last bit, go to WRITE.
- WRITE (exactly 1 cycle):
  - ser_ready=0; mem_wr=1; mem_address=current address; mem_data=assembled word.
  - Next cycle: address increments modulo 2^ADDRESS_WIDTH (0xFF -> 0x00 wraps silently); remaining count decrements.
  - Then go to DATA if count is not 0, else PAR/FIN.
- FIN (1 cycle): done=1, ser_ready=0; then IDLE.
- Bits are consumed only on ser_valid & ser_ready. ser_valid with ser_ready=0 is ignored and nothing is consumed. Bit counter advances only on a transfer, so gaps in ser_valid stall the session indefinitely.
- mem_address and mem_data hold their last values outside WRITE; mem_wr=0 outside WRITE.
- Throughput: DATA_WIDTH+1 cycles per word at best.
- Latency: last data bit transfer -> mem_wr high on the next cycle.
- start during FIN is ignored; the session is accepted only from IDLE.

Optional Feature:
DM_LOADER_PARITY_EN.
- Defined:
  - After the final WRITE (or after LEN when N=0), enter PAR and accept one bit, expected equal to the XOR of all payload bits; the XOR is 0 for N=0.
  - On mismatch, set err=1 in the FIN cycle. err stays high until the next accepted start or rst. Writes already issued are not undone.
- Undefined: PAR state is absent, no parity bit is consumed, and err is tied to 0.

Test Plan:
1. Reset: rst=1 for 2 cycles -> all outputs 0 and busy=0. Then send start with no stimulus -> busy=1, ser_ready=1, mem_wr stays 0.
2. Basic load (DATA_WIDTH=4, ADDRESS_WIDTH=4): start; bits addr=0x3, N=0x2, words 0xA, 0x5 -> mem_wr pulses at addr 3 data 0xA and at addr 4 data 0x5, then done=1 for 1 cycle, busy=0.
3. Wrap (ADDRESS_WIDTH=4, DATA_WIDTH=1): addr=0xF, N=2, data 1,0 -> writes at 0xF then 0x0.
4. Stall/backpressure: deassert ser_valid for 5 cycles mid-word; hold ser_valid=1 through WRITE -> same writes as the unstalled run. No bit is consumed during WRITE (ser_ready=0 there).
5. N=0 and start-while-busy: N=0 -> no mem_wr, done one cycle after LEN completes. A second start pulse inside a session -> no effect. Assert rst during DATA -> no mem_wr, state IDLE.
6. DM_LOADER_PARITY_EN: words 0xA, 0x5 (XOR of bits = 0):
   - Parity bit 0 -> err=0.
   - Parity bit 1 -> err=1 after done, cleared by the next start.
